cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_tag_store.sv | 47 ++++
 rtl/cache_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared widths and FSM state encoding for the direct-mapped write-back cache controller.
package cache_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int TAG_W  = 5;
   localparam int IDX_W  = 7;
   localparam int OFF_W  = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB,
      FILL,
      RESP
   } state_t;

endpackage

// File: rtl/cache_tag_store.sv
// Per-line valid/dirty/tag storage: combinational read port, one registered write port.
// Valid and dirty clear synchronously on rst; tags need no reset because valid gates them.
module cache_tag_store
   import cache_pkg::*;
#(
   parameter int TAG_BITS  = cache_pkg::TAG_W,
   parameter int IDX_BITS  = cache_pkg::IDX_W,
   parameter int NUM_LINES = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic                rd_valid,
   output logic                rd_dirty,
   output logic [TAG_BITS-1:0] rd_tag,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic                wr_valid,
   input  logic                wr_dirty,
   input  logic [TAG_BITS-1:0] wr_tag
);

   logic [NUM_LINES-1:0] valid;
   logic [NUM_LINES-1:0] dirty;
   logic [TAG_BITS-1:0]  tags [NUM_LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= wr_valid;
         dirty[wr_idx] <= wr_dirty;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx] <= wr_tag;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_dirty = dirty[rd_idx];
   assign rd_tag   = tags[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller; hit completes 2 cycles after request.
// Misses write back a dirty victim word by word, then fill; each word waits for mem_ack.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W     = cache_pkg::ADDR_W,
   parameter int DATA_W     = cache_pkg::DATA_W,
   parameter int LINE_WORDS = 16,
   parameter int NUM_LINES  = 128
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         cpu_req,
   input  logic                                         cpu_we,
   input  logic [ADDR_W-1:0]                            cpu_addr,
   input  logic [DATA_W-1:0]                            cpu_wdata,
   output logic [DATA_W-1:0]                            cpu_rdata,
   output logic                                         cpu_ready,
   output logic [$clog2(NUM_LINES)+$clog2(LINE_WORDS)-1:0] dary_addr,
   output logic                                         dary_we,
   output logic [DATA_W-1:0]                            dary_wdata,
   input  logic [DATA_W-1:0]                            dary_rdata,
   output logic                                         mem_req,
   output logic                                         mem_we,
   output logic [ADDR_W-1:0]                            mem_addr,
   output logic [DATA_W-1:0]                            mem_wdata,
   input  logic [DATA_W-1:0]                            mem_rdata,
   input  logic                                         mem_ack
);

   localparam int OFF_BITS = $clog2(LINE_WORDS);
   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;

   state_t              state;
   logic [OFF_BITS-1:0] k;
   logic [ADDR_W-1:0]   req_addr;
   logic                req_we;
   logic [DATA_W-1:0]   req_wdata;
   logic                wb_mem;   // WB word phase: 0 = array read issued, 1 = word on the bus
   logic                replay;   // first LOOKUP cycle after a fill only re-reads the array

   logic [TAG_BITS-1:0] req_tag;
   logic [IDX_BITS-1:0] req_idx;
   logic [OFF_BITS-1:0] req_off;
   logic                ts_valid, ts_dirty;
   logic [TAG_BITS-1:0] ts_tag;
   logic                ts_we, ts_wvalid, ts_wdirty;
   logic [TAG_BITS-1:0] ts_wtag;
   logic                hit, last, acked;

   assign req_tag = req_addr[ADDR_W-1 -: TAG_BITS];
   assign req_idx = req_addr[OFF_BITS +: IDX_BITS];
   assign req_off = req_addr[OFF_BITS-1:0];
   assign hit     = ts_valid && (ts_tag == req_tag);
   assign last    = (k == OFF_BITS'(LINE_WORDS - 1));
   assign acked   = mem_req && mem_ack;

   cache_tag_store #(
      .TAG_BITS  (TAG_BITS),
      .IDX_BITS  (IDX_BITS),
      .NUM_LINES (NUM_LINES)
   ) u_tag_store (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (req_idx),
      .rd_valid (ts_valid),
      .rd_dirty (ts_dirty),
      .rd_tag   (ts_tag),
      .wr_en    (ts_we),
      .wr_idx   (req_idx),
      .wr_valid (ts_wvalid),
      .wr_dirty (ts_wdirty),
      .wr_tag   (ts_wtag)
   );

   always_comb begin
      ts_we     = 1'b0;
      ts_wvalid = 1'b0;
      ts_wdirty = 1'b0;
      ts_wtag   = req_tag;
      if (state == LOOKUP && !replay && hit && req_we) begin
         ts_we     = 1'b1;
         ts_wvalid = 1'b1;
         ts_wdirty = 1'b1;
      end else if (state == WB && wb_mem && acked && last) begin
         // victim is gone once written back; its frame is about to be refilled
         ts_we = 1'b1;
      end else if (state == FILL && acked && last) begin
         ts_we     = 1'b1;
         ts_wvalid = 1'b1;
      end
   end

   // The array has one cycle of read latency, so the address leads the state that consumes the data.
   always_comb begin
      dary_addr  = {req_idx, req_off};
      dary_we    = 1'b0;
      dary_wdata = '0;
      case (state)
         IDLE:   dary_addr = cpu_addr[IDX_BITS+OFF_BITS-1:0];
         LOOKUP: begin
            if (!replay && hit && req_we) begin
               dary_we    = 1'b1;
               dary_wdata = req_wdata;
            end
         end
         WB:     dary_addr = {req_idx, k};
         FILL:   begin
            dary_addr = {req_idx, k};
            if (acked) begin
               dary_we    = 1'b1;
               dary_wdata = mem_rdata;
            end
         end
         default: ;
      endcase
   end

   // The array keeps re-reading {index, k} while the word waits on the bus, so the data is stable.
   assign mem_wdata = (state == WB && mem_req) ? dary_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         wb_mem    <= 1'b0;
         replay    <= 1'b0;
         req_addr  <= '0;
         req_we    <= 1'b0;
         req_wdata <= '0;
         cpu_rdata <= '0;
         cpu_ready <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  req_addr  <= cpu_addr;
                  req_we    <= cpu_we;
                  req_wdata <= cpu_wdata;
                  replay    <= 1'b0;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (replay) begin
                  replay <= 1'b0;
               end else if (hit) begin
                  if (!req_we) begin
                     cpu_rdata <= dary_rdata;
                  end
                  cpu_ready <= 1'b1;
                  state     <= RESP;
               end else begin
                  k      <= '0;
                  wb_mem <= 1'b0;
                  state  <= (ts_valid && ts_dirty) ? WB : FILL;
               end
            end
            WB: begin
               if (!wb_mem) begin
                  wb_mem   <= 1'b1;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b1;
                  mem_addr <= {ts_tag, req_idx, k};
               end else if (mem_ack) begin
                  wb_mem  <= 1'b0;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (last) begin
                     k     <= '0;
                     state <= FILL;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            FILL: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {req_tag, req_idx, k};
               end else if (mem_ack) begin
                  if (last) begin
                     mem_req <= 1'b0;
                     k       <= '0;
                     replay  <= 1'b1;
                     state   <= LOOKUP;
                  end else begin
                     k        <= k + 1'b1;
                     mem_addr <= {req_tag, req_idx, k + 1'b1};
                  end
               end
            end
            RESP: begin
               cpu_ready <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
